// File: rtl/store_queue_forward_pkg.sv
// Shared entry type and wrap-aware pointer helpers for the store queue.
package store_queue_forward_pkg;

  typedef struct packed {
    logic valid;
    logic resolved;
    logic committed;
  } sq_entry_t;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // a is older than b when it sits closer to head; a b that already fell behind head has nothing older
  function automatic logic is_older(input int unsigned a, input int unsigned b,
                                    input int unsigned head, input int unsigned ptrw);
    int unsigned mask;
    int unsigned da;
    int unsigned db;
    mask = (32'd1 << ptrw) - 32'd1;
    da   = (a - head) & mask;
    db   = (b - head) & mask;
    if (db > ((mask + 32'd1) >> 1)) db = 0;
    return da < db;
  endfunction

endpackage

// File: rtl/store_queue_forward_if.sv
// Store queue port bundle: dispatch, execute, commit, flush, drain and load lookup.
interface store_queue_forward_if
  import store_queue_forward_pkg::*;
#(
  parameter int unsigned SQ_DEPTH = 8,
  parameter int unsigned XLEN     = 32
);
  localparam int unsigned IDXW = $clog2(SQ_DEPTH);
  localparam int unsigned PTRW = ptr_width(SQ_DEPTH);
  localparam int unsigned BW   = XLEN / 8;

  logic            alloc_valid;
  logic            alloc_ready;
  logic [IDXW-1:0] alloc_idx;
  logic [PTRW-1:0] alloc_age;
  logic            ex_valid;
  logic [IDXW-1:0] ex_idx;
  logic [XLEN-1:0] ex_addr;
  logic [BW-1:0]   ex_be;
  logic [XLEN-1:0] ex_data;
  logic            commit_valid;
  logic            flush;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic [BW-1:0]   mem_req_be;
  logic [XLEN-1:0] mem_req_data;
  logic            ld_valid;
  logic [XLEN-1:0] ld_addr;
  logic [BW-1:0]   ld_be;
  logic [PTRW-1:0] ld_age;
  logic            ld_resp_valid;
  logic            ld_hit;
  logic            ld_stall;
  logic [XLEN-1:0] ld_data;
  logic            sq_empty;
  logic            sq_full;

  modport master (
    output alloc_valid, ex_valid, ex_idx, ex_addr, ex_be, ex_data, commit_valid, flush,
           mem_req_ready, ld_valid, ld_addr, ld_be, ld_age,
    input  alloc_ready, alloc_idx, alloc_age, mem_req_valid, mem_req_addr, mem_req_be,
           mem_req_data, ld_resp_valid, ld_hit, ld_stall, ld_data, sq_empty, sq_full
  );

  modport slave (
    input  alloc_valid, ex_valid, ex_idx, ex_addr, ex_be, ex_data, commit_valid, flush,
           mem_req_ready, ld_valid, ld_addr, ld_be, ld_age,
    output alloc_ready, alloc_idx, alloc_age, mem_req_valid, mem_req_addr, mem_req_be,
           mem_req_data, ld_resp_valid, ld_hit, ld_stall, ld_data, sq_empty, sq_full
  );

endinterface

// File: rtl/store_queue_forward_fwd_search.sv
// Age-filtered priority search of older stores for a load; purely combinational.
// SQ_BYTE_MERGE_EN selects per-byte merging instead of single-store forwarding.
module store_queue_forward_fwd_search
  import store_queue_forward_pkg::*;
#(
  parameter int unsigned SQ_DEPTH = 8,
  parameter int unsigned XLEN     = 32,
  localparam int unsigned IDXW    = $clog2(SQ_DEPTH),
  localparam int unsigned PTRW    = ptr_width(SQ_DEPTH),
  localparam int unsigned BW      = XLEN / 8
) (
  input  logic [SQ_DEPTH-1:0]           ent_valid,
  input  logic [SQ_DEPTH-1:0]           ent_resolved,
  input  logic [SQ_DEPTH-1:0][XLEN-1:0] ent_addr,
  input  logic [SQ_DEPTH-1:0][BW-1:0]   ent_be,
  input  logic [SQ_DEPTH-1:0][XLEN-1:0] ent_data,
  input  logic [PTRW-1:0]               head,
  input  logic [XLEN-1:0]               ld_addr,
  input  logic [BW-1:0]                 ld_be,
  input  logic [PTRW-1:0]               ld_age,
  output logic                          hit,
  output logic                          stall,
  output logic [XLEN-1:0]               data
);

  logic            any_unres;
  logic [IDXW-1:0] idx;
  logic            word_hit;
  logic            unused_lsb;
`ifdef SQ_BYTE_MERGE_EN
  logic [BW-1:0]   cov;
  logic [XLEN-1:0] merged;
`else
  logic            found;
  logic [BW-1:0]   found_be;
  logic [XLEN-1:0] found_data;
`endif

  always_comb begin
    any_unres  = 1'b0;
    idx        = '0;
    word_hit   = 1'b0;
    unused_lsb = ^ld_addr[1:0];
    hit        = 1'b0;
    stall      = 1'b0;
    data       = '0;
`ifdef SQ_BYTE_MERGE_EN
    cov        = '0;
    merged     = '0;
`else
    found      = 1'b0;
    found_be   = '0;
    found_data = '0;
`endif
    // oldest to newest, so a later match overrides an earlier one
    for (int unsigned k = 0; k < SQ_DEPTH; k++) begin
      idx        = head[IDXW-1:0] + IDXW'(k);
      unused_lsb = unused_lsb ^ (^ent_addr[k][1:0]);
      word_hit   = ent_addr[idx][XLEN-1:2] == ld_addr[XLEN-1:2];
      if (ent_valid[idx] && is_older(32'(head) + k, 32'(ld_age), 32'(head), PTRW)) begin
        if (!ent_resolved[idx]) begin
          any_unres = 1'b1;
        end else if (word_hit) begin
`ifdef SQ_BYTE_MERGE_EN
          for (int unsigned b = 0; b < BW; b++) begin
            if (ent_be[idx][b]) begin
              cov[b]          = 1'b1;
              merged[8*b +: 8] = ent_data[idx][8*b +: 8];
            end
          end
`else
          if ((ent_be[idx] & ld_be) != '0) begin
            found      = 1'b1;
            found_be   = ent_be[idx];
            found_data = ent_data[idx];
          end
`endif
        end
      end
    end

`ifdef SQ_BYTE_MERGE_EN
    if (any_unres) begin
      stall = 1'b1;
    end else if (((cov & ld_be) == ld_be) && (ld_be != '0)) begin
      hit = 1'b1;
      for (int unsigned b = 0; b < BW; b++) begin
        data[8*b +: 8] = ld_be[b] ? merged[8*b +: 8] : 8'h00;
      end
    end else if ((cov & ld_be) != '0) begin
      stall = 1'b1;
    end
`else
    if (any_unres) begin
      stall = 1'b1;
    end else if (found) begin
      if ((found_be & ld_be) == ld_be) begin
        hit  = 1'b1;
        data = found_data;
      end else begin
        stall = 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/store_queue_forward.sv
// Age-ordered store queue with store-to-load forwarding and in-order drain.
// SQ_BYTE_MERGE_EN enables per-byte forward merging in the search.
module store_queue_forward
  import store_queue_forward_pkg::*;
#(
  parameter int unsigned SQ_DEPTH = 8,
  parameter int unsigned XLEN     = 32
) (
  input logic                 clk,
  input logic                 rst,
  store_queue_forward_if.slave sq
);
  localparam int unsigned IDXW = $clog2(SQ_DEPTH);
  localparam int unsigned PTRW = ptr_width(SQ_DEPTH);
  localparam int unsigned BW   = XLEN / 8;

  sq_entry_t [SQ_DEPTH-1:0]      ent;
  logic [SQ_DEPTH-1:0][XLEN-1:0] ent_addr;
  logic [SQ_DEPTH-1:0][XLEN-1:0] ent_data;
  logic [SQ_DEPTH-1:0][BW-1:0]   ent_be;
  logic [SQ_DEPTH-1:0]           ent_valid;
  logic [SQ_DEPTH-1:0]           ent_resolved;
  logic [SQ_DEPTH-1:0]           flush_hit;
  logic [PTRW-1:0]               head, cmt, tail, cmt_n, flush_cnt;
  logic [IDXW-1:0]               flush_off;
  logic                          full, do_alloc, do_commit, do_drain, ex_hit;
  logic                          s_hit, s_stall;
  logic [XLEN-1:0]               s_data;
  logic                          resp_valid, resp_hit, resp_stall;
  logic [XLEN-1:0]               resp_data;

  assign full              = (head[IDXW-1:0] == tail[IDXW-1:0]) && (head[IDXW] != tail[IDXW]);
  assign sq.alloc_ready    = ~full;
  assign sq.alloc_idx      = tail[IDXW-1:0];
  assign sq.alloc_age      = tail;
  assign sq.sq_empty       = head == tail;
  assign sq.sq_full        = full;
  assign sq.mem_req_valid  = ent[head[IDXW-1:0]].valid & ent[head[IDXW-1:0]].committed &
                             ent[head[IDXW-1:0]].resolved;
  assign sq.mem_req_addr   = ent_addr[head[IDXW-1:0]];
  assign sq.mem_req_be     = ent_be[head[IDXW-1:0]];
  assign sq.mem_req_data   = ent_data[head[IDXW-1:0]];
  assign sq.ld_resp_valid  = resp_valid;
  assign sq.ld_hit         = resp_hit;
  assign sq.ld_stall       = resp_stall;
  assign sq.ld_data        = resp_data;

  assign do_alloc  = sq.alloc_valid & ~full & ~sq.flush;
  assign do_commit = sq.commit_valid & (cmt != tail);
  assign do_drain  = sq.mem_req_valid & sq.mem_req_ready;
  assign ex_hit    = sq.ex_valid & ent[sq.ex_idx].valid;
  assign cmt_n     = cmt + PTRW'(do_commit);
  assign flush_cnt = tail - cmt_n;

  // flush discards the uncommitted span cmt_n..tail-1, measured after this cycle's commit
  always_comb begin
    ent_valid    = '0;
    ent_resolved = '0;
    flush_hit    = '0;
    flush_off    = '0;
    for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
      ent_valid[i]    = ent[i].valid;
      ent_resolved[i] = ent[i].resolved;
      flush_off       = IDXW'(i) - cmt_n[IDXW-1:0];
      flush_hit[i]    = {1'b0, flush_off} < flush_cnt;
    end
  end

  store_queue_forward_fwd_search #(
    .SQ_DEPTH (SQ_DEPTH),
    .XLEN     (XLEN)
  ) u_search (
    .ent_valid    (ent_valid),
    .ent_resolved (ent_resolved),
    .ent_addr     (ent_addr),
    .ent_be       (ent_be),
    .ent_data     (ent_data),
    .head         (head),
    .ld_addr      (sq.ld_addr),
    .ld_be        (sq.ld_be),
    .ld_age       (sq.ld_age),
    .hit          (s_hit),
    .stall        (s_stall),
    .data         (s_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      cmt        <= '0;
      tail       <= '0;
      ent        <= '0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_stall <= 1'b0;
      resp_data  <= '0;
    end else begin
      if (ex_hit) ent[sq.ex_idx].resolved <= 1'b1;
      if (do_commit) ent[cmt[IDXW-1:0]].committed <= 1'b1;
      if (do_drain) begin
        ent[head[IDXW-1:0]] <= '0;
        head                <= head + PTRW'(1);
      end
      if (do_alloc) begin
        ent[tail[IDXW-1:0]] <= '{valid: 1'b1, resolved: 1'b0, committed: 1'b0};
        tail                <= tail + PTRW'(1);
      end
      cmt <= cmt_n;
      if (sq.flush) begin
        tail <= cmt_n;
        for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
          if (flush_hit[i]) ent[i] <= '0;
        end
      end
      resp_valid <= sq.ld_valid & ~sq.flush;
      resp_hit   <= sq.ld_valid & ~sq.flush & s_hit;
      resp_stall <= sq.ld_valid & ~sq.flush & s_stall;
      resp_data  <= (sq.ld_valid & ~sq.flush & s_hit) ? s_data : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (ex_hit) begin
      ent_addr[sq.ex_idx] <= sq.ex_addr;
      ent_be[sq.ex_idx]   <= sq.ex_be;
      ent_data[sq.ex_idx] <= sq.ex_data;
    end
  end

endmodule

// File: tb/tb_store_queue_forward.sv
// Directed plus randomized bench for store_queue_forward against a sequence-numbered queue model.
module tb_store_queue_forward;
  import store_queue_forward_pkg::*;

  localparam int D = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  store_queue_forward_if #(.SQ_DEPTH(D), .XLEN(32)) sif ();
  store_queue_forward #(.SQ_DEPTH(D), .XLEN(32)) dut (.clk(clk), .rst(rst), .sq(sif));

  typedef struct {
    int          seq;
    bit          resolved;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } st_t;

  st_t q[$];
  int head_seq, cmt_seq, tail_seq, ld_seq;
  int passed, total;
  logic [31:0] apool [4] = '{32'h100, 32'h102, 32'h104, 32'h200};
  logic [3:0]  bpool [6] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h6, 4'h8};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic void model_lookup(input logic [31:0] a, input logic [3:0] lbe, input int age_seq,
                                       output logic hit, output logic stall, output logic [31:0] data);
    bit unres;
    unres = 0; hit = 0; stall = 0; data = '0;
    foreach (q[i]) if (q[i].seq < age_seq && !q[i].resolved) unres = 1;
`ifdef SQ_BYTE_MERGE_EN
    begin
      logic [3:0]  cov;
      logic [31:0] md;
      cov = '0; md = '0;
      for (int b = 0; b < 4; b++) if (lbe[b]) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
          if (q[i].seq < age_seq && q[i].resolved && q[i].addr[31:2] == a[31:2] && q[i].be[b]) begin
            cov[b] = 1'b1;
            md[8*b +: 8] = q[i].data[8*b +: 8];
            break;
          end
        end
      end
      if (unres) stall = 1;
      else if (cov == lbe && lbe != 0) begin hit = 1; data = md; end
      else if (cov != 0) stall = 1;
    end
`else
    begin
      int newest;
      newest = -1;
      for (int i = 0; i < q.size(); i++)
        if (q[i].seq < age_seq && q[i].resolved && q[i].addr[31:2] == a[31:2] && (q[i].be & lbe) != 0)
          newest = i;
      if (unres) stall = 1;
      else if (newest >= 0) begin
        if ((q[newest].be & lbe) == lbe) begin hit = 1; data = q[newest].data; end
        else stall = 1;
      end
    end
`endif
  endfunction

  task automatic model_step();
    bit drain;
    int pre_size;
    st_t n;
    pre_size = q.size();
    drain = q.size() > 0 && q[0].seq < cmt_seq && q[0].resolved && sif.mem_req_ready;
    if (sif.ex_valid)
      foreach (q[i]) if (q[i].seq % D == int'(sif.ex_idx)) begin
        q[i].resolved = 1; q[i].addr = sif.ex_addr; q[i].be = sif.ex_be; q[i].data = sif.ex_data;
      end
    if (sif.commit_valid && cmt_seq < tail_seq) cmt_seq++;
    if (drain) begin void'(q.pop_front()); head_seq++; end
    if (sif.flush) begin
      while (q.size() > 0 && q[q.size()-1].seq >= cmt_seq) void'(q.pop_back());
      tail_seq = cmt_seq;
    end else if (sif.alloc_valid && pre_size < D) begin
      n.seq = tail_seq; n.resolved = 0; n.addr = '0; n.be = '0; n.data = '0;
      q.push_back(n);
      tail_seq++;
    end
  endtask

  task automatic cycle();
    logic ev, eh, es;
    logic [31:0] ed;
    bit mv;
    #4;
    if (!rst) begin
      chk("alloc_ready", 32'(sif.alloc_ready), 32'(q.size() < D));
      chk("alloc_idx", 32'(sif.alloc_idx), 32'(tail_seq % D));
      chk("alloc_age", 32'(sif.alloc_age), 32'(tail_seq % (2*D)));
      chk("sq_empty", 32'(sif.sq_empty), 32'(q.size() == 0));
      chk("sq_full", 32'(sif.sq_full), 32'(q.size() == D));
      mv = q.size() > 0 && q[0].seq < cmt_seq && q[0].resolved;
      chk("mem_req_valid", 32'(sif.mem_req_valid), 32'(mv));
      if (mv) begin
        chk("mem_req_addr", sif.mem_req_addr, q[0].addr);
        chk("mem_req_be", 32'(sif.mem_req_be), 32'(q[0].be));
        chk("mem_req_data", sif.mem_req_data, q[0].data);
      end
    end
    ev = sif.ld_valid && !sif.flush && !rst;
    eh = 0; es = 0; ed = '0;
    if (ev) model_lookup(sif.ld_addr, sif.ld_be, ld_seq, eh, es, ed);
    if (rst) begin q.delete(); head_seq = 0; cmt_seq = 0; tail_seq = 0; end
    else model_step();
    @(posedge clk); #1;
    chk("ld_resp_valid", 32'(sif.ld_resp_valid), 32'(ev));
    chk("ld_hit", 32'(sif.ld_hit), 32'(eh));
    chk("ld_stall", 32'(sif.ld_stall), 32'(es));
    chk("ld_data", sif.ld_data, ed);
  endtask

  task automatic idle();
    sif.alloc_valid = 0; sif.ex_valid = 0; sif.ex_idx = '0; sif.ex_addr = '0; sif.ex_be = '0;
    sif.ex_data = '0; sif.commit_valid = 0; sif.flush = 0; sif.mem_req_ready = 0;
    sif.ld_valid = 0; sif.ld_addr = '0; sif.ld_be = '0; sif.ld_age = '0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; cycle(); rst = 0;
  endtask

  task automatic ex(input int idx, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    idle(); sif.ex_valid = 1; sif.ex_idx = 3'(idx); sif.ex_addr = a; sif.ex_be = be; sif.ex_data = d;
    cycle();
  endtask

  task automatic load(input logic [31:0] a, input logic [3:0] be, input int age);
    idle(); ld_seq = age; sif.ld_valid = 1; sif.ld_addr = a; sif.ld_be = be; sif.ld_age = ld_seq[3:0];
    cycle();
  endtask

  initial begin
    passed = 0; total = 0; ld_seq = 0;
    head_seq = 0; cmt_seq = 0; tail_seq = 0;
    idle(); rst = 1; cycle(); cycle(); rst = 0;
    chk("rst_alloc_ready", 32'(sif.alloc_ready), 32'd1);
    chk("rst_empty", 32'(sif.sq_empty), 32'd1);
    chk("rst_full", 32'(sif.sq_full), 32'd0);
    chk("rst_mem_valid", 32'(sif.mem_req_valid), 32'd0);
    chk("rst_resp", {28'd0, sif.ld_resp_valid, sif.ld_hit, sif.ld_stall, 1'b0}, 32'd0);
    chk("rst_ld_data", sif.ld_data, 32'd0);

    // fill to full, then a rejected ninth allocation
    for (int i = 0; i < D; i++) begin
      idle(); sif.alloc_valid = 1;
      chk("fill_idx", 32'(sif.alloc_idx), 32'(i));
      cycle();
    end
    idle(); sif.alloc_valid = 1; cycle();
    chk("full_flag", 32'(sif.sq_full), 32'd1);
    chk("full_ready", 32'(sif.alloc_ready), 32'd0);
    chk("full_age", 32'(sif.alloc_age), 32'd8);

    // newest older store wins; age snapshot hides younger store
    do_reset();
    idle(); sif.alloc_valid = 1; cycle(); cycle();
    ex(0, 32'h100, 4'hF, 32'hDEADBEEF);
    ex(1, 32'h100, 4'hF, 32'h12345678);
    load(32'h100, 4'hF, 2);
    chk("fwd_newest", sif.ld_data, 32'h12345678);
    load(32'h100, 4'hF, 1);
    chk("fwd_between", sif.ld_data, 32'hDEADBEEF);

    // unresolved older store stalls, then resolves elsewhere to a miss
    do_reset();
    idle(); sif.alloc_valid = 1; cycle();
    load(32'h200, 4'hF, 1);
    chk("unres_stall", 32'(sif.ld_stall), 32'd1);
    ex(0, 32'h300, 4'hF, 32'h55);
    load(32'h200, 4'hF, 1);
    chk("resolved_miss", {30'd0, sif.ld_hit, sif.ld_stall}, 32'd0);

    // partial coverage by newest store
    do_reset();
    idle(); sif.alloc_valid = 1; cycle(); cycle();
    ex(0, 32'h100, 4'hC, 32'hAABB0000);
    ex(1, 32'h100, 4'h3, 32'h99991234);
    load(32'h100, 4'hF, 2);
`ifdef SQ_BYTE_MERGE_EN
    chk("merge_data", sif.ld_data, 32'hAABB1234);
`else
    chk("partial_stall", 32'(sif.ld_stall), 32'd1);
`endif

    // flush keeps committed stores, which then drain under backpressure
    do_reset();
    idle(); sif.alloc_valid = 1; for (int i = 0; i < 4; i++) cycle();
    for (int i = 0; i < 4; i++) ex(i, 32'h400 + 32'(4*i), 4'hF, 32'(i + 1));
    idle(); sif.commit_valid = 1; cycle(); cycle();
    idle(); sif.flush = 1; cycle();
    chk("flush_tail", 32'(sif.alloc_idx), 32'd2);
    idle();
    for (int i = 0; i < 3; i++) begin cycle(); chk("hold_valid", 32'(sif.mem_req_valid), 32'd1); end
    sif.mem_req_ready = 1; cycle(); cycle();
    chk("drained_empty", 32'(sif.sq_empty), 32'd1);

    // steady alloc/ex/commit/drain stream across pointer wrap
    do_reset();
    for (int t = 0; t < 20; t++) begin
      idle();
      sif.alloc_valid = 1; sif.commit_valid = 1; sif.mem_req_ready = 1;
      if (t > 0) begin
        sif.ex_valid = 1; sif.ex_idx = 3'((t - 1) % D); sif.ex_addr = 32'h100;
        sif.ex_be = 4'hF; sif.ex_data = 32'hA0000000 + 32'(t - 1);
      end
      ld_seq = (tail_seq > 0) ? tail_seq - 1 : 0;
      sif.ld_valid = 1; sif.ld_addr = 32'h100; sif.ld_be = 4'hF; sif.ld_age = ld_seq[3:0];
      cycle();
    end
    chk("wrap_fwd", sif.ld_data, 32'hA0000011);

    // randomized traffic
    do_reset();
    for (int n = 0; n < 400; n++) begin
      int lo, pick;
      idle();
      rst = ($urandom_range(99) == 0);
      sif.alloc_valid   = ($urandom_range(2) != 0);
      sif.commit_valid  = $urandom_range(1) != 0;
      sif.flush         = ($urandom_range(29) == 0);
      sif.mem_req_ready = ($urandom_range(2) != 0);
      sif.ex_valid      = $urandom_range(1) != 0;
      if (q.size() > 0 && $urandom_range(3) != 0) begin
        pick = int'($urandom_range(q.size() - 1));
        sif.ex_idx = 3'(q[pick].seq % D);
      end else sif.ex_idx = 3'($urandom_range(D - 1));
      sif.ex_addr = apool[$urandom_range(3)];
      sif.ex_be   = bpool[$urandom_range(5)];
      sif.ex_data = $urandom;
      sif.ld_valid = $urandom_range(1) != 0;
      sif.ld_addr  = apool[$urandom_range(3)];
      sif.ld_be    = bpool[$urandom_range(5)];
      lo = (head_seq >= 2) ? head_seq - 2 : 0;
      ld_seq = int'($urandom_range(tail_seq, lo));
      sif.ld_age = ld_seq[3:0];
      cycle();
    end
    rst = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
